// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - shared SimpleRISC widths, forwarding tag and source types
package simplerisc_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wb;
    logic             ld;
  } fwd_tag_t;

  typedef enum logic [1:0] {
    SRC_RF  = 2'd0,
    SRC_ALU = 2'd1,
    SRC_MA  = 2'd2,
    SRC_RW  = 2'd3
  } fwd_src_e;

  localparam fwd_tag_t TAG_BUBBLE = '0;

  // r0 is deliberately not special-cased: a writer of r0 forwards like any other register
  function automatic logic tag_match(input fwd_tag_t t,
                                     input logic [REG_W-1:0] rs,
                                     input logic use_en);
    return t.v & t.wb & (t.rd == rs) & use_en;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass selection, newest producing stage wins
module fwd_mux
  import simplerisc_pkg::fwd_tag_t;
  import simplerisc_pkg::fwd_src_e;
  import simplerisc_pkg::SRC_RF;
  import simplerisc_pkg::SRC_ALU;
  import simplerisc_pkg::SRC_MA;
  import simplerisc_pkg::SRC_RW;
  import simplerisc_pkg::tag_match;
#(
  parameter int DATA_W = 32
) (
  input  fwd_tag_t                         tag_alu,
  input  fwd_tag_t                         tag_ma,
  input  fwd_tag_t                         tag_rw,
  input  logic [simplerisc_pkg::REG_W-1:0] rs,
  input  logic                             use_en,
  input  logic [DATA_W-1:0]                rf_data,
  input  logic [DATA_W-1:0]                alu_data,
  input  logic [DATA_W-1:0]                ma_data,
  input  logic [DATA_W-1:0]                rw_data,
  output logic [DATA_W-1:0]                data,
  output fwd_src_e                         src,
  output logic                             ld_hit
);

  logic m_alu;
  logic m_ma;
  logic m_rw;

  assign m_alu  = tag_match(tag_alu, rs, use_en);
  assign m_ma   = tag_match(tag_ma,  rs, use_en);
  assign m_rw   = tag_match(tag_rw,  rs, use_en);

  // A load in ALU has no data yet; the top level stalls on ld_hit
  assign ld_hit = m_alu & tag_alu.ld;

  always_comb begin
    src  = SRC_RF;
    data = rf_data;
    if (m_alu && !tag_alu.ld) begin
      src  = SRC_ALU;
      data = alu_data;
    end else if (m_ma) begin
      src  = SRC_MA;
      data = ma_data;
    end else if (m_rw) begin
      src  = SRC_RW;
      data = rw_data;
    end
  end

endmodule

// File: rtl/of_forward_unit.sv
// rtl/of_forward_unit.sv - OF operand forwarding, load-use interlock and debug counters
module of_forward_unit
  import simplerisc_pkg::fwd_tag_t;
  import simplerisc_pkg::fwd_src_e;
  import simplerisc_pkg::SRC_RF;
  import simplerisc_pkg::TAG_BUBBLE;
#(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_OF,
  input  logic [REG_W-1:0]  rs1_OF,
  input  logic [REG_W-1:0]  rs2_OF,
  input  logic              use1_OF,
  input  logic              use2_OF,
  input  logic [REG_W-1:0]  rd_OF,
  input  logic              isWb_OF,
  input  logic              isLd_OF,
  input  logic              flush,
  input  logic [DATA_W-1:0] op1_RF,
  input  logic [DATA_W-1:0] op2_RF,
  input  logic [DATA_W-1:0] res_ALU,
  input  logic [DATA_W-1:0] res_MA,
  input  logic [DATA_W-1:0] res_RW,
  output logic [DATA_W-1:0] op1_fwd,
  output logic [DATA_W-1:0] op2_fwd,
  output logic              stall,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  fwdCnt
);

  fwd_tag_t tag_alu_q;
  fwd_tag_t tag_ma_q;
  fwd_tag_t tag_rw_q;
  fwd_tag_t tag_alu_d;

  fwd_src_e src1;
  fwd_src_e src2;
  logic     ld_hit1;
  logic     ld_hit2;
  logic     fwd_evt;

  fwd_mux #(.DATA_W(DATA_W)) u_mux1 (
    .tag_alu  (tag_alu_q),
    .tag_ma   (tag_ma_q),
    .tag_rw   (tag_rw_q),
    .rs       (rs1_OF),
    .use_en   (use1_OF),
    .rf_data  (op1_RF),
    .alu_data (res_ALU),
    .ma_data  (res_MA),
    .rw_data  (res_RW),
    .data     (op1_fwd),
    .src      (src1),
    .ld_hit   (ld_hit1)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_mux2 (
    .tag_alu  (tag_alu_q),
    .tag_ma   (tag_ma_q),
    .tag_rw   (tag_rw_q),
    .rs       (rs2_OF),
    .use_en   (use2_OF),
    .rf_data  (op2_RF),
    .alu_data (res_ALU),
    .ma_data  (res_MA),
    .rw_data  (res_RW),
    .data     (op2_fwd),
    .src      (src2),
    .ld_hit   (ld_hit2)
  );

  // Flush overrides the interlock: the younger instruction is discarded anyway
  assign stall   = valid_OF & ~flush & (ld_hit1 | ld_hit2);
  assign fwd_evt = ~stall & ((src1 != SRC_RF) | (src2 != SRC_RF));

  always_comb begin
    tag_alu_d = TAG_BUBBLE;
    if (valid_OF && !stall && !flush) begin
      tag_alu_d.v  = 1'b1;
      tag_alu_d.rd = rd_OF;
      tag_alu_d.wb = isWb_OF;
      tag_alu_d.ld = isLd_OF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_alu_q <= TAG_BUBBLE;
      tag_ma_q  <= TAG_BUBBLE;
      tag_rw_q  <= TAG_BUBBLE;
    end else begin
      tag_rw_q  <= tag_ma_q;
      tag_ma_q  <= tag_alu_q;
      tag_alu_q <= tag_alu_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      fwdCnt   <= '0;
    end else begin
      if (stall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (fwd_evt && (fwdCnt != '1)) begin
        fwdCnt <= fwdCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_of_forward_unit.sv
// tb/tb_of_forward_unit.sv - directed self-checking bench for of_forward_unit
module tb_of_forward_unit;

  logic        clk;
  logic        reset;
  logic        valid_OF;
  logic [4:0]  rs1_OF, rs2_OF, rd_OF;
  logic        use1_OF, use2_OF, isWb_OF, isLd_OF, flush;
  logic [31:0] op1_RF, op2_RF, res_ALU, res_MA, res_RW;
  logic [31:0] op1_fwd, op2_fwd, s_op1_fwd, s_op2_fwd;
  logic        stall, s_stall;
  logic [15:0] stallCnt, fwdCnt;
  logic [7:0]  s_stallCnt, s_fwdCnt;

  int ntests = 0;
  int nerr   = 0;

  of_forward_unit dut (
    .clk(clk), .reset(reset), .valid_OF(valid_OF),
    .rs1_OF(rs1_OF), .rs2_OF(rs2_OF), .use1_OF(use1_OF), .use2_OF(use2_OF),
    .rd_OF(rd_OF), .isWb_OF(isWb_OF), .isLd_OF(isLd_OF), .flush(flush),
    .op1_RF(op1_RF), .op2_RF(op2_RF),
    .res_ALU(res_ALU), .res_MA(res_MA), .res_RW(res_RW),
    .op1_fwd(op1_fwd), .op2_fwd(op2_fwd), .stall(stall),
    .stallCnt(stallCnt), .fwdCnt(fwdCnt)
  );

  of_forward_unit #(.CNT_W(8)) u_sat (
    .clk(clk), .reset(reset), .valid_OF(valid_OF),
    .rs1_OF(rs1_OF), .rs2_OF(rs2_OF), .use1_OF(use1_OF), .use2_OF(use2_OF),
    .rd_OF(rd_OF), .isWb_OF(isWb_OF), .isLd_OF(isLd_OF), .flush(flush),
    .op1_RF(op1_RF), .op2_RF(op2_RF),
    .res_ALU(res_ALU), .res_MA(res_MA), .res_RW(res_RW),
    .op1_fwd(s_op1_fwd), .op2_fwd(s_op2_fwd), .stall(s_stall),
    .stallCnt(s_stallCnt), .fwdCnt(s_fwdCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_of(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic wb, input logic ld);
    valid_OF = v; rs1_OF = r1; use1_OF = u1; rs2_OF = r2; use2_OF = u2;
    rd_OF = rd; isWb_OF = wb; isLd_OF = ld;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    set_of(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_of(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    ntests++;
    if (stall !== 1'b0 || op1_fwd !== 32'h1111_1111 || op2_fwd !== 32'h2222_2222) begin
      nerr++;
      $display("FAIL reset_outputs: stall=%0b op1=%h op2=%h, required 0 11111111 22222222", stall, op1_fwd, op2_fwd);
    end
    ntests++;
    if (stallCnt !== 16'd0 || fwdCnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_counters: stallCnt=%0d fwdCnt=%0d, required 0 0", stallCnt, fwdCnt);
    end
    do_reset();
  endtask

  task automatic test_alu_forward();
    do_reset();
    set_of(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_of(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    op1_RF = 32'h0; res_ALU = 32'h0000_0011;
    #1;
    ntests++;
    if (op1_fwd !== 32'h11 || stall !== 1'b0 || op2_fwd !== 32'h2222_2222) begin
      nerr++;
      $display("FAIL alu_forward: op1=%h stall=%0b op2=%h, required 00000011 0 22222222", op1_fwd, stall, op2_fwd);
    end
    tick();
    ntests++;
    if (fwdCnt !== 16'd1 || stallCnt !== 16'd0) begin
      nerr++;
      $display("FAIL alu_forward_cnt: fwdCnt=%0d stallCnt=%0d, required 1 0", fwdCnt, stallCnt);
    end
    op1_RF = 32'h1111_1111; res_ALU = 32'hA0A0_A0A0;
  endtask

  task automatic test_load_use();
    do_reset();
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_of(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
    res_MA = 32'hDEAD_BEEF;
    #1;
    ntests++;
    if (stall !== 1'b1) begin
      nerr++;
      $display("FAIL load_use_stall: stall=%0b, required 1", stall);
    end
    tick();
    ntests++;
    if (stall !== 1'b0 || op1_fwd !== 32'hDEAD_BEEF || stallCnt !== 16'd1) begin
      nerr++;
      $display("FAIL load_use_resolve: stall=%0b op1=%h stallCnt=%0d, required 0 deadbeef 1", stall, op1_fwd, stallCnt);
    end
    tick();
    ntests++;
    if (stallCnt !== 16'd1 || fwdCnt !== 16'd1) begin
      nerr++;
      $display("FAIL load_use_cnt: stallCnt=%0d fwdCnt=%0d, required 1 1", stallCnt, fwdCnt);
    end
    res_MA = 32'hB0B0_B0B0;
  endtask

  task automatic test_priority();
    do_reset();
    res_ALU = 32'd5; res_MA = 32'h77; res_RW = 32'd9;
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0);
    tick();
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_of(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0);
    #1;
    ntests++;
    if (op2_fwd !== 32'd5 || op1_fwd !== 32'd5 || stall !== 1'b0) begin
      nerr++;
      $display("FAIL priority_alu_over_rw: op1=%h op2=%h stall=%0b, required 5 5 0", op1_fwd, op2_fwd, stall);
    end
    do_reset();
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_of(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    set_of(1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0);
    #1;
    ntests++;
    if (op2_fwd !== 32'd9 || op1_fwd !== 32'h1111_1111) begin
      nerr++;
      $display("FAIL priority_rw_only: op1=%h op2=%h, required 11111111 9", op1_fwd, op2_fwd);
    end
    res_ALU = 32'hA0A0_A0A0; res_MA = 32'hB0B0_B0B0; res_RW = 32'hC0C0_C0C0;
  endtask

  task automatic test_no_use_bubble();
    do_reset();
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    set_of(1'b1, 5'd6, 1'b0, 5'd6, 1'b1, 5'd1, 1'b0, 1'b0);
    #1;
    ntests++;
    if (op1_fwd !== 32'h1111_1111 || op2_fwd !== 32'hA0A0_A0A0) begin
      nerr++;
      $display("FAIL no_use: op1=%h op2=%h, required 11111111 a0a0a0a0", op1_fwd, op2_fwd);
    end
    do_reset();
    set_of(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_of(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd1, 1'b0, 1'b0);
    #1;
    ntests++;
    if (op1_fwd !== 32'h1111_1111 || op2_fwd !== 32'h2222_2222 || stall !== 1'b0) begin
      nerr++;
      $display("FAIL bubble_no_match: op1=%h op2=%h stall=%0b, required 11111111 22222222 0", op1_fwd, op2_fwd, stall);
    end
  endtask

  task automatic test_flush_load_use();
    do_reset();
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_of(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    ntests++;
    if (stall !== 1'b0) begin
      nerr++;
      $display("FAIL flush_stall: stall=%0b, required 0", stall);
    end
    tick();
    flush = 1'b0;
    set_of(1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 5'd1, 1'b0, 1'b0);
    #1;
    ntests++;
    if (op1_fwd !== 32'h1111_1111 || op2_fwd !== 32'hB0B0_B0B0 || stall !== 1'b0) begin
      nerr++;
      $display("FAIL flush_bubble: op1=%h op2=%h stall=%0b, required 11111111 b0b0b0b0 0", op1_fwd, op2_fwd, stall);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_of(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    set_of(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_of(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1;
    ntests++;
    if (stall !== 1'b1 || fwdCnt !== 16'd1) begin
      nerr++;
      $display("FAIL pre_reset_stall: stall=%0b fwdCnt=%0d, required 1 1", stall, fwdCnt);
    end
    reset = 1'b1;
    #1;
    ntests++;
    if (stall !== 1'b0 || stallCnt !== 16'd0 || fwdCnt !== 16'd0 || op1_fwd !== 32'h1111_1111) begin
      nerr++;
      $display("FAIL async_reset: stall=%0b stallCnt=%0d fwdCnt=%0d op1=%h, required 0 0 0 11111111", stall, stallCnt, fwdCnt, op1_fwd);
    end
    tick();
    reset = 1'b0;
    #1;
    ntests++;
    if (stall !== 1'b0 || op1_fwd !== 32'h1111_1111) begin
      nerr++;
      $display("FAIL post_reset: stall=%0b op1=%h, required 0 11111111", stall, op1_fwd);
    end
  endtask

  task automatic test_back_to_back_saturation();
    logic prev_stall;
    logic double_stall;
    do_reset();
    set_of(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    prev_stall = 1'b0;
    double_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (stall && prev_stall) double_stall = 1'b1;
      prev_stall = stall;
    end
    ntests++;
    if (double_stall !== 1'b0) begin
      nerr++;
      $display("FAIL single_cycle_stall: consecutive stall seen=%0b, required 0", double_stall);
    end
    ntests++;
    if (stallCnt !== 16'd300 || fwdCnt !== 16'd299) begin
      nerr++;
      $display("FAIL back_to_back_cnt: stallCnt=%0d fwdCnt=%0d, required 300 299", stallCnt, fwdCnt);
    end
    ntests++;
    if (s_stallCnt !== 8'hFF || s_fwdCnt !== 8'hFF) begin
      nerr++;
      $display("FAIL saturation: stallCnt=%h fwdCnt=%h, required ff ff", s_stallCnt, s_fwdCnt);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    op1_RF = 32'h1111_1111; op2_RF = 32'h2222_2222;
    res_ALU = 32'hA0A0_A0A0; res_MA = 32'hB0B0_B0B0; res_RW = 32'hC0C0_C0C0;
    set_of(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_alu_forward();
    test_load_use();
    test_priority();
    test_no_use_bubble();
    test_flush_load_use();
    test_reset_mid_stall();
    test_back_to_back_saturation();
    $display("[TB] %0d tests run, %0d failed", ntests, nerr);
    $finish;
  end

endmodule
